// File: rtl/sata_tx_framer_if.sv
// Transport-to-link handshake and link-to-scrambler bus for the SATA TX framer.
// s_data/s_valid/s_last/s_ready use valid/ready semantics: a dword transfers on a
// rising edge where s_valid && s_ready are both high. The source holds s_data and
// s_last while s_valid is high and s_ready is low.
interface sata_tx_framer_if;
  logic        phy_rdy;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        tx_hold;
  logic [31:0] tx_data;
  logic        tx_is_prim;
  logic        scram_en;
  logic        scram_rst;
  logic        frame_done;
  logic        tx_abort;
  logic        len_err;

  // Framer side.
  modport master (
    input  phy_rdy, s_data, s_valid, s_last, tx_hold,
    output s_ready, tx_data, tx_is_prim, scram_en, scram_rst,
           frame_done, tx_abort, len_err
  );

  // Transport / PHY environment side.
  modport slave (
    output phy_rdy, s_data, s_valid, s_last, tx_hold,
    input  s_ready, tx_data, tx_is_prim, scram_en, scram_rst,
           frame_done, tx_abort, len_err
  );
endinterface

// File: rtl/sata_tx_framer.sv
// SATA link-layer transmit framer: wraps payload dwords in SOF / CRC / EOF,
// inserts HOLD while the source stalls or the remote requests HOLD, and idles
// with SYNC. Every output except s_ready is registered, so each dword appears
// on tx_data one cycle after the state that produced it.
module sata_tx_framer #(
  parameter int MAX_DWORDS = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  sata_tx_framer_if.master        bus,
  output logic [2:0]              state_dbg
);

  localparam logic [31:0] PRIM_SYNC = 32'hB5B5957C;
  localparam logic [31:0] PRIM_SOF  = 32'h3737B57C;
  localparam logic [31:0] PRIM_EOF  = 32'hD5D5B57C;
  localparam logic [31:0] PRIM_HOLD = 32'hD5D5AA7C;
  localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT  = 32'h52325032;
  localparam int          CNT_W     = $clog2(MAX_DWORDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_CRC  = 3'd3,
    ST_EOF  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        crc_q, crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        tx_data_q, tx_data_d;
  logic               tx_is_prim_q, tx_is_prim_d;
  logic               scram_en_q, scram_en_d;
  logic               scram_rst_q, scram_rst_d;
  logic               frame_done_q, frame_done_d;
  logic               tx_abort_q, tx_abort_d;
  logic               len_err_q, len_err_d;
  logic               accept;
  logic               at_limit;

  // 32 bits of CRC-32 per dword, MSB first, no reflection.
  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign bus.s_ready    = (state_q == ST_DATA) && !bus.tx_hold && bus.phy_rdy;
  assign accept         = bus.s_valid && bus.s_ready;
  // The dword being accepted now is number MAX_DWORDS of the frame.
  assign at_limit       = (cnt_q == CNT_W'(MAX_DWORDS - 1));

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_is_prim = tx_is_prim_q;
  assign bus.scram_en   = scram_en_q;
  assign bus.scram_rst  = scram_rst_q;
  assign bus.frame_done = frame_done_q;
  assign bus.tx_abort   = tx_abort_q;
  assign bus.len_err    = len_err_q;
  assign state_dbg      = state_q;

  // Next state, CRC/counter update and the dword to emit next cycle.
  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    tx_data_d    = PRIM_SYNC;
    tx_is_prim_d = 1'b1;
    scram_en_d   = 1'b0;
    scram_rst_d  = 1'b0;
    frame_done_d = 1'b0;
    tx_abort_d   = 1'b0;
    len_err_d    = 1'b0;

    if (state_q != ST_IDLE && !bus.phy_rdy) begin
      // Link lost mid-frame: drop it and go back to SYNC.
      state_d    = ST_IDLE;
      tx_abort_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.s_valid && bus.phy_rdy) state_d = ST_SOF;
        end
        ST_SOF: begin
          tx_data_d   = PRIM_SOF;
          scram_rst_d = 1'b1;
          crc_d       = CRC_INIT;
          cnt_d       = '0;
          state_d     = ST_DATA;
        end
        ST_DATA: begin
          if (accept) begin
            tx_data_d    = bus.s_data;
            tx_is_prim_d = 1'b0;
            scram_en_d   = 1'b1;
            crc_d        = crc32_step(crc_q, bus.s_data);
            cnt_d        = cnt_q + CNT_W'(1);
            if (bus.s_last) begin
              state_d = ST_CRC;
            end else if (at_limit) begin
              state_d   = ST_CRC;
              len_err_d = 1'b1;
            end
          end else begin
            tx_data_d = PRIM_HOLD;
          end
        end
        ST_CRC: begin
          if (bus.tx_hold) begin
            tx_data_d = PRIM_HOLD;
          end else begin
            tx_data_d    = crc_q;
            tx_is_prim_d = 1'b0;
            scram_en_d   = 1'b1;
            state_d      = ST_EOF;
          end
        end
        ST_EOF: begin
          tx_data_d    = PRIM_EOF;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, CRC, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      crc_q        <= CRC_INIT;
      cnt_q        <= '0;
      tx_data_q    <= PRIM_SYNC;
      tx_is_prim_q <= 1'b1;
      scram_en_q   <= 1'b0;
      scram_rst_q  <= 1'b0;
      frame_done_q <= 1'b0;
      tx_abort_q   <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_is_prim_q <= tx_is_prim_d;
      scram_en_q   <= scram_en_d;
      scram_rst_q  <= scram_rst_d;
      frame_done_q <= frame_done_d;
      tx_abort_q   <= tx_abort_d;
      len_err_q    <= len_err_d;
    end
  end

endmodule

// File: tb/tb_sata_tx_framer.sv
// Bench for sata_tx_framer: directed cycle-exact frames, abort and reset cases,
// then randomized streams checked against a frame-level scoreboard.
module tb_sata_tx_framer;

  localparam int          MAXD      = 4;
  localparam logic [31:0] P_SYNC    = 32'hB5B5957C;
  localparam logic [31:0] P_SOF     = 32'h3737B57C;
  localparam logic [31:0] P_EOF     = 32'hD5D5B57C;
  localparam logic [31:0] P_HOLD    = 32'hD5D5AA7C;
  localparam logic [32:0] POLY33    = {1'b1, 32'h04C11DB7};
  localparam logic [31:0] CRC_INIT  = 32'h52325032;

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;

  sata_tx_framer_if bus_if ();

  sata_tx_framer #(.MAX_DWORDS(MAXD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.master),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // CRC as a polynomial remainder: (M(x) + I(x)*x^(n-32)) * x^32 mod P(x),
  // computed by long division over the explicit bit string of the frame.
  function automatic logic [31:0] crc_ref(input logic [31:0] dw[$]);
    bit          m[$];
    int          n;
    logic [31:0] r;
    foreach (dw[k]) for (int b = 31; b >= 0; b--) m.push_back(dw[k][b]);
    n = m.size();
    for (int j = 0; j < 32; j++) m.push_back(1'b0);
    for (int j = 0; j < 32; j++) m[j] = m[j] ^ CRC_INIT[31-j];
    for (int i = 0; i < n; i++)
      if (m[i]) for (int j = 0; j <= 32; j++) m[i+j] = m[i+j] ^ POLY33[32-j];
    for (int j = 0; j < 32; j++) r[31-j] = m[n+j];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {is_prim, dword} for every non-SYNC/HOLD output
  bit          mon_en = 1'b0;
  int          len_err_seen = 0, len_err_exp = 0;
  int          abort_seen = 0, done_seen = 0, frames_exp = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [32:0] obs;
      obs = {bus_if.tx_is_prim, bus_if.tx_data};
      check("done_on_eof", 64'(bus_if.frame_done), 64'(obs == {1'b1, P_EOF}));
      if (bus_if.len_err)    len_err_seen++;
      if (bus_if.tx_abort)   abort_seen++;
      if (bus_if.frame_done) done_seen++;
      if (obs == {1'b1, P_SYNC} || obs == {1'b1, P_HOLD}) begin
        check("prim_scram_en", 64'(bus_if.scram_en), 64'd0);
      end else begin
        check("exp_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("stream", 64'(obs), 64'(exp_q.pop_front()));
        check("scram_en", 64'(bus_if.scram_en), 64'(!bus_if.tx_is_prim));
        if (obs == {1'b1, P_SOF}) check("sof_scram_rst", 64'(bus_if.scram_rst), 64'd1);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_stream(input logic [31:0] d[$], input bit l[$], input int hold_pct, input int gap_pct);
    logic [31:0] fr[$];
    int          cnt, i, guard;
    bit          acc;
    cnt = 0;
    foreach (d[k]) begin
      if (cnt == 0) exp_q.push_back({1'b1, P_SOF});
      exp_q.push_back({1'b0, d[k]});
      fr.push_back(d[k]);
      cnt++;
      if (l[k] || cnt == MAXD) begin
        if (!l[k]) len_err_exp++;
        exp_q.push_back({1'b0, crc_ref(fr)});
        exp_q.push_back({1'b1, P_EOF});
        frames_exp++;
        fr.delete();
        cnt = 0;
      end
    end
    i = 0;
    guard = 0;
    while (i < d.size() && guard < 5000) begin
      bus_if.s_valid = ($urandom_range(99) >= gap_pct);
      bus_if.s_data  = d[i];
      bus_if.s_last  = l[i];
      bus_if.tx_hold = ($urandom_range(99) < hold_pct);
      @(negedge clk);
      acc = bus_if.s_valid && bus_if.s_ready;
      step();
      if (acc) i++;
      guard++;
    end
    check("stream_consumed", 64'(i), 64'(d.size()));
    bus_if.s_valid = 1'b0;
    bus_if.s_last  = 1'b0;
    bus_if.tx_hold = 1'b0;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
    check("stream_drained", 64'(exp_q.size()), 64'd0);
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] q[$];
    logic [31:0] a, b, c;
    logic [31:0] d[$];
    bit          l[$];
    int          n;

    rst = 1'b1;
    bus_if.phy_rdy = 1'b1;
    bus_if.s_data  = '0;
    bus_if.s_valid = 1'b0;
    bus_if.s_last  = 1'b0;
    bus_if.tx_hold = 1'b0;
    step();
    step();
    check("rst_data",  64'(bus_if.tx_data), 64'(P_SYNC));
    check("rst_prim",  64'(bus_if.tx_is_prim), 64'd1);
    check("rst_flags", 64'({bus_if.scram_en, bus_if.scram_rst, bus_if.frame_done,
                            bus_if.tx_abort, bus_if.len_err}), 64'd0);
    rst = 1'b0;

    // Idle with no traffic: SYNC every cycle.
    for (int k = 0; k < 4; k++) begin
      step();
      check("idle_sync", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b1, P_SYNC}));
    end

    // One-dword frame of zero.
    bus_if.s_data = 32'h0; bus_if.s_last = 1'b1; bus_if.s_valid = 1'b1;
    step(); check("f1_sync", 64'(bus_if.tx_data), 64'(P_SYNC));
    step(); check("f1_sof", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b1, P_SOF}));
            check("f1_scram_rst", 64'(bus_if.scram_rst), 64'd1);
    step(); check("f1_pay", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b0, 32'h0}));
            check("f1_scram_en", 64'(bus_if.scram_en), 64'd1);
    bus_if.s_valid = 1'b0; bus_if.s_last = 1'b0;
    q = '{32'h0};
    step(); check("f1_crc", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b0, crc_ref(q)}));
            check("f1_crc_scram", 64'(bus_if.scram_en), 64'd1);
    step(); check("f1_eof", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b1, P_EOF}));
            check("f1_done", 64'(bus_if.frame_done), 64'd1);
    step(); check("f1_after", 64'(bus_if.tx_data), 64'(P_SYNC));
            check("f1_done_clr", 64'(bus_if.frame_done), 64'd0);

    // Three-dword frame with a two-cycle remote HOLD mid-payload.
    a = $urandom(); b = $urandom(); c = $urandom();
    bus_if.s_data = a; bus_if.s_last = 1'b0; bus_if.s_valid = 1'b1;
    step(); step();
    step(); check("h_a", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b0, a}));
    bus_if.s_data = b; bus_if.tx_hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("h_hold", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b1, P_HOLD}));
      check("h_hold_scram", 64'(bus_if.scram_en), 64'd0);
    end
    bus_if.tx_hold = 1'b0;
    step(); check("h_b", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b0, b}));
    bus_if.s_data = c; bus_if.s_last = 1'b1;
    step(); check("h_c", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b0, c}));
    bus_if.s_valid = 1'b0; bus_if.s_last = 1'b0;
    q = '{a, b, c};
    step(); check("h_crc", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b0, crc_ref(q)}));
    step(); check("h_eof_done", 64'({bus_if.frame_done, bus_if.tx_data}), 64'({1'b1, P_EOF}));
    step();

    // phy_rdy lost after the second payload dword.
    bus_if.s_data = a; bus_if.s_valid = 1'b1;
    step(); step();
    step(); check("p_a", 64'(bus_if.tx_data), 64'(a));
    bus_if.s_data = b;
    step(); check("p_b", 64'(bus_if.tx_data), 64'(b));
    bus_if.s_valid = 1'b0; bus_if.phy_rdy = 1'b0;
    step(); check("p_abort", 64'(bus_if.tx_abort), 64'd1);
            check("p_sync", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b1, P_SYNC}));
    bus_if.phy_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("p_no_eof", 64'({bus_if.tx_abort, bus_if.frame_done, bus_if.tx_data == P_EOF}), 64'd0);
    end

    // Reset while the CRC dword is pending.
    bus_if.s_data = c; bus_if.s_last = 1'b1; bus_if.s_valid = 1'b1;
    step(); step();
    step(); check("r_pay", 64'(bus_if.tx_data), 64'(c));
    bus_if.s_valid = 1'b0; bus_if.s_last = 1'b0; rst = 1'b1;
    step(); check("r_sync", 64'({bus_if.tx_is_prim, bus_if.tx_data}), 64'({1'b1, P_SYNC}));
            check("r_no_pulse", 64'({bus_if.tx_abort, bus_if.frame_done, bus_if.scram_en}), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("r_no_eof", 64'({bus_if.frame_done, bus_if.tx_data == P_EOF}), 64'd0);
    end

    // Scoreboard phase: 6-dword stream truncated at MAXD, then random streams.
    mon_en = 1'b1;
    d.delete(); l.delete();
    for (int k = 0; k < 6; k++) begin
      d.push_back($urandom());
      l.push_back(k == 5);
    end
    run_stream(d, l, 0, 0);
    check("trunc_len_err", 64'(len_err_seen), 64'd1);

    for (int r = 0; r < 5; r++) begin
      d.delete(); l.delete();
      n = $urandom_range(30, 15);
      for (int k = 0; k < n; k++) begin
        d.push_back($urandom());
        l.push_back((k == n - 1) || ($urandom_range(3) == 0));
      end
      run_stream(d, l, 25, 25);
    end
    mon_en = 1'b0;
    check("len_err_count", 64'(len_err_seen), 64'(len_err_exp));
    check("frame_count", 64'(done_seen), 64'(frames_exp));
    check("abort_count", 64'(abort_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
